// File: rtl/rv_wb_arbiter_pkg.sv
// Shared types for the two-requester Wishbone arbiter: FSM state encoding,
// the captured bus request record, and the fixed shape of a fetch request.
package rv_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_INS = 2'd1,
        BUS_DAT = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] wdat;
        logic        we;
        logic [3:0]  sel;
    } wb_req_t;

    // Fetches are always full-word reads with no write data.
    function automatic wb_req_t fetch_req(input logic [31:0] adr);
        wb_req_t r;
        r.adr  = adr;
        r.wdat = 32'h0000_0000;
        r.we   = 1'b0;
        r.sel  = 4'b1111;
        return r;
    endfunction

endpackage

// File: rtl/rv_wb_timeout.sv
// Saturating bus-cycle watchdog: flags the last allowed cycle of an
// unanswered bus cycle. A zero limit disables the guard entirely.
module rv_wb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
            localparam logic [CW-1:0] ONE   = CW'(1);

            logic [CW-1:0] count_r;

            // Count elapsed bus cycles, holding at the limit instead of wrapping.
            always_ff @(posedge i_clk) begin
                if (i_reset || i_clear) begin
                    count_r <= '0;
                end else if (i_run && (count_r != LIMIT)) begin
                    count_r <= count_r + ONE;
                end else begin
                    count_r <= count_r;
                end
            end

            // count_r holds cycles already elapsed, so the limit-th cycle is when it reads LIMIT-1.
            assign o_expired = i_run && (count_r >= (LIMIT - ONE));
        end
    endgenerate

endmodule

// File: rtl/rv_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic bus between instruction
// fetch and load/store, with registered bus outputs and one-cycle responses.
module rv_wb_arbiter
    import rv_wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ins_req,
    input  logic [31:0] i_ins_adr,
    output logic [31:0] o_ins_dat,
    output logic        o_ins_ack,
    output logic        o_ins_err,
    input  logic        i_dat_req,
    input  logic [31:0] i_dat_adr,
    input  logic [31:0] i_dat_wdat,
    input  logic        i_dat_we,
    input  logic [3:0]  i_dat_sel,
    output logic [31:0] o_dat_rdat,
    output logic        o_dat_ack,
    output logic        o_dat_err,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_stb,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err
);

    arb_state_t state_r;
    logic       last_dat_r;
    logic       grant_dat_s;
    logic       grant_ins_s;
    logic       on_bus_s;
    logic       expired_s;
    logic       ok_s;
    wb_req_t    ins_fields_s;
    wb_req_t    dat_fields_s;
    wb_req_t    grant_fields_s;

    assign ins_fields_s = fetch_req(i_ins_adr);
    assign dat_fields_s = '{adr: i_dat_adr, wdat: i_dat_wdat, we: i_dat_we, sel: i_dat_sel};
    assign on_bus_s     = (state_r == BUS_INS) || (state_r == BUS_DAT);
    assign ok_s         = i_wb_ack && !i_wb_err;

    // Pick a winner for the IDLE cycle; on a tie, favour the side not served last.
    always_comb begin
        grant_dat_s = 1'b0;
        grant_ins_s = 1'b0;
        if (i_dat_req && (!i_ins_req || !last_dat_r)) begin
            grant_dat_s = 1'b1;
        end else if (i_ins_req) begin
            grant_ins_s = 1'b1;
        end else begin
            grant_dat_s = 1'b0;
            grant_ins_s = 1'b0;
        end
    end

    assign grant_fields_s = grant_dat_s ? dat_fields_s : ins_fields_s;

    rv_wb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (!on_bus_s),
        .i_run    (on_bus_s),
        .o_expired(expired_s)
    );

    // Arbiter FSM with bus capture registers and the response demux.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r    <= IDLE;
            last_dat_r <= 1'b0;
            o_wb_adr   <= 32'h0000_0000;
            o_wb_dat   <= 32'h0000_0000;
            o_wb_we    <= 1'b0;
            o_wb_sel   <= 4'b0000;
            o_wb_stb   <= 1'b0;
            o_wb_cyc   <= 1'b0;
            o_ins_ack  <= 1'b0;
            o_ins_err  <= 1'b0;
            o_ins_dat  <= 32'h0000_0000;
            o_dat_ack  <= 1'b0;
            o_dat_err  <= 1'b0;
            o_dat_rdat <= 32'h0000_0000;
        end else begin
            o_ins_ack <= 1'b0;
            o_ins_err <= 1'b0;
            o_dat_ack <= 1'b0;
            o_dat_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_dat_s || grant_ins_s) begin
                        o_wb_adr   <= grant_fields_s.adr;
                        o_wb_dat   <= grant_fields_s.wdat;
                        o_wb_we    <= grant_fields_s.we;
                        o_wb_sel   <= grant_fields_s.sel;
                        o_wb_cyc   <= 1'b1;
                        o_wb_stb   <= 1'b1;
                        last_dat_r <= grant_dat_s;
                        state_r    <= grant_dat_s ? BUS_DAT : BUS_INS;
                    end
                end
                BUS_INS, BUS_DAT: begin
                    // Error beats ack; timeout only matters while the slave is silent.
                    if (i_wb_ack || i_wb_err || expired_s) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        state_r  <= DONE;
                        if (state_r == BUS_DAT) begin
                            o_dat_ack  <= ok_s;
                            o_dat_err  <= !ok_s;
                            o_dat_rdat <= ok_s ? i_wb_dat : 32'h0000_0000;
                        end else begin
                            o_ins_ack <= ok_s;
                            o_ins_err <= !ok_s;
                            o_ins_dat <= ok_s ? i_wb_dat : 32'h0000_0000;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    o_wb_cyc <= 1'b0;
                    o_wb_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Directed bench for rv_wb_arbiter (TIMEOUT_CYCLES = 4): latency, round-robin
// alternation, wait states, timeout, ack+err priority and mid-cycle reset.
module tb_rv_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ins_req;
    logic [31:0] ins_adr;
    logic [31:0] ins_dat;
    logic        ins_ack, ins_err;
    logic        dat_req;
    logic [31:0] dat_adr, dat_wdat;
    logic        dat_we;
    logic [3:0]  dat_sel;
    logic [31:0] dat_rdat;
    logic        dat_ack, dat_err;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic        wb_we, wb_stb, wb_cyc, wb_ack, wb_err;
    logic [3:0]  wb_sel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv_wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_ins_req(ins_req), .i_ins_adr(ins_adr), .o_ins_dat(ins_dat),
        .o_ins_ack(ins_ack), .o_ins_err(ins_err),
        .i_dat_req(dat_req), .i_dat_adr(dat_adr), .i_dat_wdat(dat_wdat),
        .i_dat_we(dat_we), .i_dat_sel(dat_sel), .o_dat_rdat(dat_rdat),
        .o_dat_ack(dat_ack), .o_dat_err(dat_err),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat_o), .o_wb_we(wb_we), .o_wb_sel(wb_sel),
        .o_wb_stb(wb_stb), .o_wb_cyc(wb_cyc),
        .i_wb_dat(wb_dat_i), .i_wb_ack(wb_ack), .i_wb_err(wb_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transfer starting from IDLE; exp_dat selects which side must win.
    task automatic bus_xfer(input string tag, input logic exp_dat, input logic [31:0] rd, input int waits);
        tick();
        chk({tag, "_cyc"}, {31'd0, wb_cyc}, 32'd1);
        chk({tag, "_stb"}, {31'd0, wb_stb}, 32'd1);
        chk({tag, "_adr"}, wb_adr, exp_dat ? dat_adr : ins_adr);
        chk({tag, "_we"},  {31'd0, wb_we}, exp_dat ? {31'd0, dat_we} : 32'd0);
        chk({tag, "_sel"}, {28'd0, wb_sel}, exp_dat ? {28'd0, dat_sel} : 32'hF);
        chk({tag, "_wdat"}, wb_dat_o, exp_dat ? dat_wdat : 32'd0);
        for (int i = 0; i < waits; i++) begin
            tick();
            chk({tag, "_cyc_wait"}, {31'd0, wb_cyc}, 32'd1);
        end
        wb_ack   = 1'b1;
        wb_dat_i = rd;
        tick();
        wb_ack = 1'b0;
        chk({tag, "_cyc_done"}, {31'd0, wb_cyc}, 32'd0);
        chk({tag, "_ins_ack"}, {31'd0, ins_ack}, exp_dat ? 32'd0 : 32'd1);
        chk({tag, "_dat_ack"}, {31'd0, dat_ack}, exp_dat ? 32'd1 : 32'd0);
        chk({tag, "_errs"}, {30'd0, ins_err, dat_err}, 32'd0);
        chk({tag, "_rdat"}, exp_dat ? dat_rdat : ins_dat, rd);
        tick();
        chk({tag, "_pulse_end"}, {30'd0, ins_ack, dat_ack}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; ins_req = 1'b0; ins_adr = 32'd0; dat_req = 1'b0;
        dat_adr = 32'd0; dat_wdat = 32'd0; dat_we = 1'b0; dat_sel = 4'd0;
        wb_dat_i = 32'd0; wb_ack = 1'b0; wb_err = 1'b0;
        tick(); tick();
        chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
        chk("rst_sel", {28'd0, wb_sel}, 32'd0);
        chk("rst_adr", wb_adr, 32'd0);
        chk("rst_acks", {28'd0, ins_ack, ins_err, dat_ack, dat_err}, 32'd0);
        chk("rst_rdat", ins_dat | dat_rdat, 32'd0);
        rst = 1'b0;

        // Stray ack while idle must not produce a response.
        wb_ack = 1'b1; wb_dat_i = 32'h5555_5555;
        tick(); wb_ack = 1'b0;
        tick();
        chk("idle_ack_ignored", {28'd0, ins_ack, ins_err, dat_ack, dat_err}, 32'd0);
        chk("idle_cyc", {31'd0, wb_cyc}, 32'd0);

        ins_req = 1'b1; ins_adr = 32'h0000_0100;
        bus_xfer("fetch", 1'b0, 32'h0000_0013, 0);
        ins_req = 1'b0;

        // Both pending continuously: dat, ins, dat, ins.
        ins_req = 1'b1; ins_adr = 32'h0000_0104;
        dat_req = 1'b1; dat_adr = 32'h0000_0300; dat_we = 1'b0; dat_sel = 4'hF; dat_wdat = 32'h1234_5678;
        bus_xfer("rr1_dat", 1'b1, 32'hDEAD_0001, 0);
        bus_xfer("rr2_ins", 1'b0, 32'hDEAD_0002, 0);
        bus_xfer("rr3_dat", 1'b1, 32'hDEAD_0003, 1);
        bus_xfer("rr4_ins", 1'b0, 32'hDEAD_0004, 0);
        ins_req = 1'b0; dat_req = 1'b0;
        chk("rr_ins_dat_held", ins_dat, 32'hDEAD_0004);
        chk("rr_dat_rdat_held", dat_rdat, 32'hDEAD_0003);

        dat_req = 1'b1; dat_adr = 32'h0000_0203; dat_wdat = 32'hAAAA_AAAA; dat_we = 1'b1; dat_sel = 4'b1000;
        bus_xfer("store", 1'b1, 32'h0BAD_F00D, 2);
        dat_req = 1'b0;

        // Silent slave: cyc high for 4 cycles, then err.
        dat_req = 1'b1; dat_adr = 32'h0000_0400; dat_we = 1'b0; dat_sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_cyc_high", {31'd0, wb_cyc}, 32'd1);
        end
        tick();
        dat_req = 1'b0;
        chk("to_cyc_low", {31'd0, wb_cyc}, 32'd0);
        chk("to_dat_err", {31'd0, dat_err}, 32'd1);
        chk("to_dat_ack", {31'd0, dat_ack}, 32'd0);
        chk("to_rdat", dat_rdat, 32'd0);
        tick();
        chk("to_err_end", {31'd0, dat_err}, 32'd0);

        ins_req = 1'b1; ins_adr = 32'h0000_0500;
        bus_xfer("post_to_fetch", 1'b0, 32'h1111_1111, 0);
        ins_req = 1'b0;

        // Ack and err together: err wins.
        ins_req = 1'b1; ins_adr = 32'h0000_0508;
        tick();
        chk("ae_cyc", {31'd0, wb_cyc}, 32'd1);
        wb_ack = 1'b1; wb_err = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
        tick();
        wb_ack = 1'b0; wb_err = 1'b0; ins_req = 1'b0;
        chk("ae_ins_err", {31'd0, ins_err}, 32'd1);
        chk("ae_ins_ack", {31'd0, ins_ack}, 32'd0);
        chk("ae_ins_dat", ins_dat, 32'd0);
        tick();

        // Reset while a data cycle is in flight; last grant was data before reset.
        dat_req = 1'b1; dat_adr = 32'h0000_0600;
        tick();
        chk("mr_cyc_before", {31'd0, wb_cyc}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mr_cyc", {31'd0, wb_cyc}, 32'd0);
        chk("mr_stb", {31'd0, wb_stb}, 32'd0);
        chk("mr_sel", {28'd0, wb_sel}, 32'd0);
        chk("mr_pulses", {28'd0, ins_ack, ins_err, dat_ack, dat_err}, 32'd0);
        rst = 1'b0;
        ins_req = 1'b1; ins_adr = 32'h0000_0700; dat_adr = 32'h0000_0800;
        bus_xfer("mr_tie_dat", 1'b1, 32'h2222_2222, 0);
        ins_req = 1'b0; dat_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
